time_split_seq: RTL and testbench
=================================

TIME_SPLIT_SEQ -- requirements
Module: time_split_seq

Interface
REQ-001 The block SHALL have parameter IN_W, default 32, meaning the width of the binary centisecond count; legal range 20..32.
REQ-002 The block SHALL have parameter DIGITS, default 8, meaning the number of BCD display digits; legal values 4 (S:CS), 6 (M:S:CS), 8 (H:M:S:CS).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL be clocked on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, an asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, asserted when a_in holds a count to convert.
REQ-006 The block SHALL have port in_ready, output, 1 bit, asserted when the block can accept a count.
REQ-007 The block SHALL have port a_in, input, IN_W bits, the unsigned centisecond count.
REQ-008 The block SHALL have port out_valid, output, 1 bit, asserted when c_out and ovf hold a result.
REQ-009 The block SHALL have port out_ready, input, 1 bit, asserted when the consumer takes the result.
REQ-010 The block SHALL have port c_out, output, 4*DIGITS bits, the BCD digits, most significant field first, two digits per field.
REQ-011 The block SHALL have port ovf, output, 1 bit, asserted when the count exceeds the displayable maximum.

Function
REQ-012 The field divisors SHALL be constants: hours 360000, minutes 6000, seconds 100, centiseconds as the final remainder.
REQ-013 The FSM SHALL have states IDLE, DIV, PACK and DONE; DIV SHALL iterate once per field boundary, i.e. DIGITS/2-1 passes.
REQ-014 in_ready SHALL be 1 only in IDLE; a count SHALL be accepted when in_valid and in_ready are both 1, latching a_in and moving to DIV.
REQ-015 Each DIV pass SHALL be an IN_W-cycle restoring shift-subtract division of the running remainder by the pass divisor, producing one quotient bit per cycle.
REQ-016 After the last pass, the block SHALL enter PACK for one cycle, converting each field value (0..99) to two BCD digits, then enter DONE.
REQ-017 out_valid SHALL rise exactly (DIGITS/2-1)*IN_W+2 cycles after the acceptance edge (98 for the defaults).
REQ-018 In DONE, out_valid SHALL be 1 and c_out and ovf SHALL be held stable until out_ready=1, then the block SHALL return to IDLE on the next edge.
REQ-019 When out_valid, out_ready and in_valid are all 1 in the same cycle, the new count SHALL NOT be accepted; in_ready rises in the following cycle.
REQ-020 If the top-field quotient exceeds 99, ovf SHALL be 1 and every field SHALL saturate to its maximum: top field 99, then 59 for minutes/seconds and 99 for centiseconds.
REQ-021 Otherwise ovf SHALL be 0; field values below the top are bounded by their divisor and SHALL never saturate.
REQ-022 in_valid and a_in changes SHALL be ignored while in DIV, PACK or DONE.

Reset
REQ-023 While rst_n=0, the state SHALL be IDLE, in_ready 1 after release, out_valid 0, c_out all zero, ovf 0, and all datapath registers zero.
REQ-024 Reset asserted mid-conversion SHALL abort the conversion immediately with no out_valid pulse.

Configuration
REQ-025 Macro TIME_SPLIT_BLANK_EN SHALL control leading-zero blanking.
REQ-026 With TIME_SPLIT_BLANK_EN defined, leading zero digits SHALL output 4'hF down to, but excluding, the two least-significant digits, which are never blanked.
REQ-027 Without TIME_SPLIT_BLANK_EN, all digits SHALL be numeric BCD.

Verification
REQ-028 Reset: assert rst_n=0 mid-DIV; required: out_valid=0, c_out=0, and in_ready=1 one cycle after release.
REQ-029 Field split (defaults): a_in=372304; required: c_out=32'h01020304, ovf=0, out_valid exactly 98 cycles after acceptance.
REQ-030 Maximum: a_in=35999999; required: c_out=32'h99595999, ovf=0; a_in=36000000 gives c_out=32'h99595999 with ovf=1.
REQ-031 Backpressure: hold out_ready=0 for 20 cycles with in_valid=1 and changing a_in; required: c_out stable, in_ready=0, and no second acceptance until the cycle after the out_ready handshake.
REQ-032 Blanking (macro on): a_in=5 gives 32'hFFFFFF05; a_in=6005 gives 32'hFFF10005; with the macro off, a_in=5 gives 32'h00000005.
REQ-033 DIGITS=4, IN_W=20: a_in=9999 gives 16'h9999 with ovf=0; a_in=10000 gives 16'h9999 with ovf=1; latency is 22 cycles.

Source files
------------

// File: rtl/time_split_seq.sv
// Centisecond count to H:M:S:CS BCD splitter using sequential restoring division.
// Define TIME_SPLIT_BLANK_EN to blank leading zero digits (4'hF).
module time_split_seq #(
    parameter int IN_W   = 32,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       a_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   c_out,
    output logic                  ovf
);

    localparam int NF  = DIGITS / 2;
    localparam int NP  = NF - 1;
    localparam int OFS = 4 - NF;
    localparam int CW  = $clog2(IN_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_PACK = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [IN_W-1:0] D_H = IN_W'(360000);
    localparam logic [IN_W-1:0] D_M = IN_W'(6000);
    localparam logic [IN_W-1:0] D_S = IN_W'(100);

    logic [1:0]      state_q;
    logic [IN_W-1:0] num_q;
    logic [IN_W-1:0] rem_q;
    logic [CW-1:0]   bit_q;
    logic [1:0]      pass_q;
    logic            ovf_q;
    logic [6:0]      fld_q [NF];
    logic            ov_q;
    logic [4*DIGITS-1:0] c_q;
    logic            ovf_o;

    logic [2:0]      di;
    logic [IN_W-1:0] dv;
    logic [IN_W-1:0] trial;
    logic            ge;
    logic [IN_W-1:0] rem_n;
    logic [IN_W-1:0] num_n;
    logic [4*DIGITS-1:0] pk;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = ov_q;
    assign c_out     = c_q;
    assign ovf       = ovf_o;

    // Smaller displays skip the upper divisors.
    assign di = 3'(pass_q) + 3'(OFS);

    always_comb begin
        dv = D_S;
        case (di)
            3'd0:    dv = D_H;
            3'd1:    dv = D_M;
            default: dv = D_S;
        endcase
    end

    // Remainder stays below the divisor, so its top bit is always zero.
    assign trial = {rem_q[IN_W-2:0], num_q[IN_W-1]};
    assign ge    = (trial >= dv);
    assign rem_n = ge ? (trial - dv) : trial;
    assign num_n = {num_q[IN_W-2:0], ge};

    always_comb begin
        logic [6:0] v;
        pk = '0;
        for (int k = 0; k < NF; k++) begin
            v = fld_q[k];
            if (ovf_q) v = (k == 0 || k == NF - 1) ? 7'd99 : 7'd59;
            pk[4*DIGITS-1-8*k -: 8] = {4'(v / 7'd10), 4'(v % 7'd10)};
        end
`ifdef TIME_SPLIT_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int d = DIGITS - 1; d >= 2; d--) begin
                if (lead && pk[4*d +: 4] == 4'h0) pk[4*d +: 4] = 4'hF;
                else lead = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            rem_q   <= '0;
            bit_q   <= '0;
            pass_q  <= '0;
            ovf_q   <= 1'b0;
            ov_q    <= 1'b0;
            c_q     <= '0;
            ovf_o   <= 1'b0;
            for (int i = 0; i < NF; i++) fld_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        num_q   <= a_in;
                        rem_q   <= '0;
                        bit_q   <= '0;
                        pass_q  <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (bit_q == CW'(IN_W - 1)) begin
                        fld_q[pass_q] <= num_n[6:0];
                        if (pass_q == 2'd0) ovf_q <= (num_n > IN_W'(99));
                        // Remainder becomes the next pass's dividend.
                        num_q <= rem_n;
                        rem_q <= '0;
                        bit_q <= '0;
                        if (pass_q == 2'(NP - 1)) begin
                            fld_q[NF-1] <= rem_n[6:0];
                            state_q     <= S_PACK;
                        end else begin
                            pass_q <= pass_q + 2'd1;
                        end
                    end else begin
                        num_q <= num_n;
                        rem_q <= rem_n;
                        bit_q <= bit_q + CW'(1);
                    end
                end
                S_PACK: begin
                    c_q     <= pk;
                    ovf_o   <= ovf_q;
                    ov_q    <= 1'b1;
                    state_q <= S_DONE;
                end
                default: begin
                    if (out_ready) begin
                        ov_q    <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_split_seq.sv
// Self-checking bench for time_split_seq (8-digit/32-bit and 4-digit/20-bit builds).
module tb_time_split_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, ovf;
    logic [31:0] a_in = '0;
    logic [31:0] c_out;

    logic        in_valid4 = 1'b0, out_ready4 = 1'b0;
    logic        in_ready4, out_valid4, ovf4;
    logic [19:0] a4 = '0;
    logic [15:0] c4;

    int nchk = 0;
    int nfail = 0;

    time_split_seq #(.IN_W(32), .DIGITS(8)) u8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .c_out(c_out), .ovf(ovf)
    );

    time_split_seq #(.IN_W(20), .DIGITS(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .a_in(a4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .c_out(c4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: split into fields by arithmetic, saturate, then BCD.
    function automatic void model(input longint a, input int nf,
                                  output logic [31:0] c, output logic e);
        longint dv[4];
        longint f[4];
        longint r;
        logic [3:0] dg[8];
        bit lead;
        dv = '{360000, 6000, 100, 1};
        r = a;
        for (int k = 0; k < nf; k++) begin
            f[k] = r / dv[k+4-nf];
            r = r % dv[k+4-nf];
        end
        e = (f[0] > 99);
        if (e)
            for (int k = 0; k < nf; k++)
                f[k] = (k == 0 || k == nf - 1) ? 99 : 59;
        for (int k = 0; k < nf; k++) begin
            dg[2*k]   = 4'(f[k] / 10);
            dg[2*k+1] = 4'(f[k] % 10);
        end
        lead = 1'b1;
`ifdef TIME_SPLIT_BLANK_EN
        for (int i = 0; i < 2*nf - 2; i++) begin
            if (lead && dg[i] == 4'h0) dg[i] = 4'hF;
            else lead = 1'b0;
        end
`endif
        c = '0;
        for (int i = 0; i < 2*nf; i++) c = {c[27:0], dg[i]};
    endfunction

    task automatic run8(input logic [31:0] a);
        logic [31:0] ec;
        logic eo;
        int c;
        model(longint'(a), 4, ec, eo);
        a_in = a;
        in_valid = 1'b1;
        c = 0;
        while (!in_ready && c < 10) begin @(negedge clk); c++; end
        chk("hs8", in_ready, 1'b1);
        @(negedge clk);
        c = 1;
        while (!out_valid && c < 200) begin
            in_valid = 1'($urandom);
            a_in = $urandom;
            @(negedge clk);
            c++;
        end
        in_valid = 1'b0;
        chk("lat8", c, 98);
        chk("c8", c_out, ec);
        chk("ovf8", ovf, eo);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle8", {out_valid, in_ready}, 2'b01);
    endtask

    task automatic run4(input logic [19:0] a);
        logic [31:0] ec;
        logic eo;
        int c;
        model(longint'(a), 2, ec, eo);
        a4 = a;
        in_valid4 = 1'b1;
        c = 0;
        while (!in_ready4 && c < 10) begin @(negedge clk); c++; end
        chk("hs4", in_ready4, 1'b1);
        @(negedge clk);
        in_valid4 = 1'b0;
        c = 1;
        while (!out_valid4 && c < 100) begin
            a4 = 20'($urandom);
            @(negedge clk);
            c++;
        end
        chk("lat4", c, 22);
        chk("c4", c4, ec[15:0]);
        chk("ovf4", ovf4, eo);
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        chk("idle4", {out_valid4, in_ready4}, 2'b01);
    endtask

    initial begin
        logic [31:0] held, ec;
        logic eo, seen;
        int c;

        @(negedge clk);
        chk("rst_ov8", out_valid, 1'b0);
        chk("rst_c8", c_out, 32'h0);
        chk("rst_ovf8", ovf, 1'b0);
        chk("rst_ov4", out_valid4, 1'b0);
        chk("rst_c4", c4, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rdy8", in_ready, 1'b1);
        chk("rst_rdy4", in_ready4, 1'b1);

        run8(32'd372304);
        run8(32'd35999999);
        run8(32'd36000000);
        run8(32'd5);
        run8(32'd6005);
        run8(32'd0);
        run8(32'hFFFF_FFFF);
        for (int i = 0; i < 8; i++) run8($urandom_range(0, 40000000));

        run4(20'd9999);
        run4(20'd10000);
        run4(20'd0);
        run4(20'hFFFFF);
        for (int i = 0; i < 6; i++) run4(20'($urandom_range(0, 12000)));

        // Backpressure: result must hold while new counts are offered.
        a_in = 32'd123456;
        in_valid = 1'b1;
        @(negedge clk);
        c = 1;
        while (!out_valid && c < 200) begin
            a_in = $urandom;
            @(negedge clk);
            c++;
        end
        model(64'd123456, 4, ec, eo);
        chk("bp_lat", c, 98);
        chk("bp_c", c_out, ec);
        held = c_out;
        for (int i = 0; i < 20; i++) begin
            a_in = $urandom;
            in_valid = 1'b1;
            @(negedge clk);
            chk("bp_stable", c_out, held);
            chk("bp_rdy", {out_valid, in_ready}, 2'b10);
        end
        a_in = 32'd6005;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_noacc", {out_valid, in_ready}, 2'b01);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_acc", in_ready, 1'b0);
        c = 1;
        while (!out_valid && c < 200) begin @(negedge clk); c++; end
        model(64'd6005, 4, ec, eo);
        chk("bp2_lat", c, 98);
        chk("bp2_c", c_out, ec);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of a division aborts it.
        a_in = 32'd372304;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_ov", out_valid, 1'b0);
        chk("mrst_c", c_out, 32'h0);
        chk("mrst_ovf", ovf, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_rdy", in_ready, 1'b1);
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("mrst_nopulse", seen, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
